// File: rtl/data_mem_access.sv
// MEM-stage load/store unit: checks the ALU effective address, runs one req/ack bus
// transaction with timeout, and returns extended load data or an error code.
module data_mem_access #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_1000,
  parameter logic [31:0] MEM_LIMIT = 32'h0000_1FFF,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [2:0]  mem_op,
  input  logic [31:0] ALU_result,
  input  logic [31:0] store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [1:0]  resp_code
);

  typedef enum logic [2:0] {
    OP_LW  = 3'b000, OP_LH = 3'b001, OP_LHU = 3'b010, OP_LB = 3'b011,
    OP_LBU = 3'b100, OP_SW = 3'b101, OP_SH  = 3'b110, OP_SB = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  typedef enum logic [1:0] {
    CODE_OK = 2'b00, CODE_MISALIGNED = 2'b01, CODE_INVALID = 2'b10, CODE_TIMEOUT = 2'b11
  } resp_code_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e     state;
  mem_op_e    op_q;
  logic [1:0] lane_q;
  logic [7:0] wait_cnt;

  mem_op_e     op_in;
  logic        misaligned;
  logic        out_of_range;
  logic        is_store;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  assign op_in         = mem_op_e'(mem_op);
  assign mem_req_ready = (state == IDLE) && !rst;
  assign out_of_range  = (ALU_result < MEM_BASE) || (ALU_result > MEM_LIMIT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    misaligned = 1'b0;
    is_store   = 1'b0;
    be_in      = 4'b1111;
    wdata_in   = '0;
    case (op_in)
      OP_LW:         misaligned = |ALU_result[1:0];
      OP_LH, OP_LHU: misaligned = ALU_result[0];
      OP_SW: begin
        misaligned = |ALU_result[1:0];
        is_store   = 1'b1;
        wdata_in   = store_data;
      end
      OP_SH: begin
        misaligned = ALU_result[0];
        is_store   = 1'b1;
        be_in      = ALU_result[1] ? 4'b1100 : 4'b0011;
        wdata_in   = {2{store_data[15:0]}};
      end
      OP_SB: begin
        is_store = 1'b1;
        be_in    = 4'b0001 << ALU_result[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane select plus extension; stores fall through to zero.
  function automatic logic [31:0] load_extend(input mem_op_e op, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LW:   return word;
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_LW;
      lane_q     <= '0;
      wait_cnt   <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      resp_code  <= CODE_OK;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_valid) begin
            op_q      <= op_in;
            lane_q    <= ALU_result[1:0];
            wait_cnt  <= '0;
            resp_data <= '0;
            if (misaligned || out_of_range) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              // Misalignment outranks a bad address.
              resp_code  <= misaligned ? CODE_MISALIGNED : CODE_INVALID;
            end else begin
              state     <= BUS;
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_addr  <= {ALU_result[31:2], 2'b00};
              bus_be    <= be_in;
              bus_wdata <= wdata_in;
            end
          end
        end
        BUS: begin
          // An ack in the final wait cycle still completes successfully.
          if (bus_ack || wait_cnt == LAST_WAIT) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= !bus_ack;
            resp_code  <= bus_ack ? CODE_OK : CODE_TIMEOUT;
            resp_data  <= bus_ack ? load_extend(op_q, lane_q, bus_rdata) : '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          resp_data <= '0;
          resp_err  <= 1'b0;
          resp_code <= CODE_OK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: directed vector table, mid-transaction reset sequence,
// and randomized requests checked against a rule-level reference model.
module tb_data_mem_access;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LIMIT = 32'h0000_1FFF;
  localparam int          TO    = 4;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [2:0]  mem_op;
  logic [31:0] ALU_result;
  logic [31:0] store_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [1:0]  resp_code;

  data_mem_access #(.MEM_BASE(BASE), .MEM_LIMIT(LIMIT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_op(mem_op), .ALU_result(ALU_result), .store_data(store_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_code(resp_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
    int          lat;   // cycles from accept edge to the resp_valid cycle
    int          nbus;  // cycles with bus_req high
  } exp_t;

  typedef struct {
    exp_t r;
    bit   unstable;
    bit   ready_bad;
    bit   dirty;
  } obs_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_at;  // 1-based bus cycle that acks; outside 1..TO means never
    exp_t        e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built directly from access size, lane offset and masks.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata,
                                 input int ack_at);
    exp_t        e;
    int          size;
    bit          store;
    bit          mis;
    bit          inv;
    logic [31:0] mask;
    logic [31:0] v;
    size  = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
    store = (op >= SW);
    mis   = (addr % size) != 0;
    inv   = (addr < BASE) || (addr > LIMIT);
    e.addr  = addr & ~32'd3;
    e.we    = store;
    e.be    = store ? 4'(((1 << size) - 1) << (addr % 4)) : 4'hF;
    e.wdata = !store    ? 32'h0 :
              size == 4 ? sdata :
              size == 2 ? (sdata & 32'hFFFF) * 32'h0001_0001 :
                          (sdata & 32'hFF) * 32'h0101_0101;
    e.data = 32'h0;
    if (mis || inv) begin
      e.err = 1'b1; e.code = mis ? 2'd1 : 2'd2; e.lat = 1; e.nbus = 0;
    end else if (ack_at >= 1 && ack_at <= TO) begin
      e.err = 1'b0; e.code = 2'd0; e.lat = ack_at + 1; e.nbus = ack_at;
      if (!store) begin
        mask = size == 4 ? 32'hFFFF_FFFF : size == 2 ? 32'h0000_FFFF : 32'h0000_00FF;
        v    = (rdata >> ((addr % 4) * 8)) & mask;
        if ((op == LH || op == LB) && (v & ~(mask >> 1)) != 0) v = v | ~mask;
        e.data = v;
      end
    end else begin
      e.err = 1'b1; e.code = 2'd3; e.lat = TO + 1; e.nbus = TO;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge one cycle after the response pulse.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_at, output obs_t o);
    int guard;
    int cyc;
    o = '{default: '0};
    o.r.lat = -1;
    guard = 0;
    while (!mem_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 32'(mem_req_ready), 32'd1);
    mem_req_valid = 1'b1;
    mem_op        = op;
    ALU_result    = addr;
    store_data    = sdata;
    bus_ack       = 1'($urandom_range(0, 1));  // must be ignored while idle
    bus_rdata     = $urandom;
    @(negedge clk);
    // Producer keeps valid high with unrelated fields; a busy unit must ignore it.
    mem_op     = 3'($urandom);
    ALU_result = $urandom;
    store_data = $urandom;
    cyc = 1;
    while (cyc <= 40) begin
      if (resp_valid) break;
      if (mem_req_ready) o.ready_bad = 1'b1;
      if (bus_req) begin
        o.r.nbus++;
        if (o.r.nbus == 1) begin
          o.r.addr = bus_addr; o.r.be = bus_be; o.r.wdata = bus_wdata; o.r.we = bus_we;
        end else if (bus_addr !== o.r.addr || bus_be !== o.r.be ||
                     bus_wdata !== o.r.wdata || bus_we !== o.r.we) begin
          o.unstable = 1'b1;
        end
        bus_ack   = (o.r.nbus == ack_at);
        bus_rdata = (o.r.nbus == ack_at) ? rdata : $urandom;
      end else begin
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    if (resp_valid) begin
      o.r.lat  = cyc;
      o.r.data = resp_data;
      o.r.err  = resp_err;
      o.r.code = resp_code;
    end
    mem_req_valid = 1'b0;
    bus_ack       = 1'b0;
    @(negedge clk);
    o.dirty = resp_valid || bus_req;
  endtask

  task automatic compare(input string tag, input exp_t e, input obs_t o);
    check({tag, ".latency"}, o.r.lat, e.lat);
    check({tag, ".bus_cycles"}, o.r.nbus, e.nbus);
    check({tag, ".resp_data"}, o.r.data, e.data);
    check({tag, ".resp_err"}, 32'(o.r.err), 32'(e.err));
    check({tag, ".resp_code"}, 32'(o.r.code), 32'(e.code));
    if (e.nbus > 0) begin
      check({tag, ".bus_addr"}, o.r.addr, e.addr);
      check({tag, ".bus_be"}, 32'(o.r.be), 32'(e.be));
      check({tag, ".bus_wdata"}, o.r.wdata, e.wdata);
      check({tag, ".bus_we"}, 32'(o.r.we), 32'(e.we));
      check({tag, ".bus_stable"}, 32'(o.unstable), 32'd0);
    end
    check({tag, ".busy_not_ready"}, 32'(o.ready_bad), 32'd0);
    check({tag, ".single_pulse"}, 32'(o.dirty), 32'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata, input int ack,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic ewe, input logic [31:0] ed,
                              input logic [1:0] ecode, input int lat, input int nbus);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.ack_at = ack;
    v.e.addr = ea; v.e.be = ebe; v.e.wdata = ewd; v.e.we = ewe; v.e.data = ed;
    v.e.code = ecode; v.e.err = (ecode != 2'd0); v.e.lat = lat; v.e.nbus = nbus;
    return v;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    obs_t        o;
    exp_t        e;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack;
    bit          saw;

    //        op   addr          sdata         rdata         ack  bus_addr      be       wdata         we    resp_data     code  lat nbus
    tbl.push_back(mk(LW,  32'h1004, 32'h0,        32'hDEADBEEF, 1, 32'h1004, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF, 2'd0, 2, 1));
    tbl.push_back(mk(LB,  32'h1002, 32'h0,        32'h80FF7F01, 1, 32'h1000, 4'b1111, 32'h0,        1'b0, 32'hFFFFFFFF, 2'd0, 2, 1));
    tbl.push_back(mk(LBU, 32'h1003, 32'h0,        32'h80FF7F01, 1, 32'h1000, 4'b1111, 32'h0,        1'b0, 32'h00000080, 2'd0, 2, 1));
    tbl.push_back(mk(LH,  32'h1002, 32'h0,        32'h80FF7F01, 1, 32'h1000, 4'b1111, 32'h0,        1'b0, 32'hFFFF80FF, 2'd0, 2, 1));
    tbl.push_back(mk(LHU, 32'h1000, 32'h0,        32'h80FF7F01, 1, 32'h1000, 4'b1111, 32'h0,        1'b0, 32'h00007F01, 2'd0, 2, 1));
    tbl.push_back(mk(SB,  32'h1001, 32'h12345678, 32'hFFFFFFFF, 1, 32'h1000, 4'b0010, 32'h78787878, 1'b1, 32'h0,        2'd0, 2, 1));
    tbl.push_back(mk(SH,  32'h1002, 32'h12345678, 32'hFFFFFFFF, 2, 32'h1000, 4'b1100, 32'h56785678, 1'b1, 32'h0,        2'd0, 3, 2));
    tbl.push_back(mk(SW,  32'h1008, 32'hCAFEF00D, 32'h0,        1, 32'h1008, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0,        2'd0, 2, 1));
    tbl.push_back(mk(LW,  32'h1002, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        1'b0, 32'h0,        2'd1, 1, 0));
    tbl.push_back(mk(SW,  32'h0FFC, 32'h1,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        1'b0, 32'h0,        2'd2, 1, 0));
    tbl.push_back(mk(LH,  32'h0FFF, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        1'b0, 32'h0,        2'd1, 1, 0));
    tbl.push_back(mk(LB,  32'h2000, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        1'b0, 32'h0,        2'd2, 1, 0));
    tbl.push_back(mk(LW,  32'h1FFC, 32'h0,        32'h0,        0, 32'h1FFC, 4'b1111, 32'h0,        1'b0, 32'h0,        2'd3, 5, 4));
    tbl.push_back(mk(LW,  32'h1FFC, 32'h0,        32'h11223344, 4, 32'h1FFC, 4'b1111, 32'h0,        1'b0, 32'h11223344, 2'd0, 5, 4));
    tbl.push_back(mk(LBU, 32'h1FFF, 32'h0,        32'hAB000000, 2, 32'h1FFC, 4'b1111, 32'h0,        1'b0, 32'h000000AB, 2'd0, 3, 2));
    tbl.push_back(mk(SB,  32'h1FFF, 32'h000000C3, 32'h0,        3, 32'h1FFC, 4'b1000, 32'hC3C3C3C3, 1'b1, 32'h0,        2'd0, 4, 3));

    rst = 1'b1; mem_req_valid = 1'b0; mem_op = LW; ALU_result = '0; store_data = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset.ready",      32'(mem_req_ready), 32'd0);
    check("reset.bus_req",    32'(bus_req), 32'd0);
    check("reset.bus_we",     32'(bus_we), 32'd0);
    check("reset.bus_addr",   bus_addr, 32'd0);
    check("reset.bus_be",     32'(bus_be), 32'd0);
    check("reset.bus_wdata",  bus_wdata, 32'd0);
    check("reset.resp_valid", 32'(resp_valid), 32'd0);
    check("reset.resp_data",  resp_data, 32'd0);
    check("reset.resp_err",   32'(resp_err), 32'd0);
    check("reset.resp_code",  32'(resp_code), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset.ready", 32'(mem_req_ready), 32'd1);

    foreach (tbl[i]) begin
      run_req(tbl[i].op, tbl[i].addr, tbl[i].sdata, tbl[i].rdata, tbl[i].ack_at, o);
      compare($sformatf("vec%0d", i), tbl[i].e, o);
    end

    // Reset asserted in the second cycle of a stalled bus wait.
    mem_req_valid = 1'b1; mem_op = LW; ALU_result = 32'h1010; bus_ack = 1'b0;
    @(negedge clk);
    mem_req_valid = 1'b0;
    check("rst_mid.bus_cycle1", 32'(bus_req), 32'd1);
    @(negedge clk);
    check("rst_mid.bus_cycle2", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.bus_req_dropped", 32'(bus_req), 32'd0);
    check("rst_mid.no_resp",         32'(resp_valid), 32'd0);
    check("rst_mid.ready_in_reset",  32'(mem_req_ready), 32'd0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || bus_req) saw = 1'b1;
    end
    check("rst_mid.quiet_after", 32'(saw), 32'd0);
    check("rst_mid.ready_after", 32'(mem_req_ready), 32'd1);
    run_req(LW, 32'h1010, 32'h0, 32'h0BADF00D, 1, o);
    compare("rst_mid.fresh_lw",
            mk(LW, 32'h1010, 32'h0, 32'h0BADF00D, 1, 32'h1010, 4'b1111, 32'h0, 1'b0,
               32'h0BADF00D, 2'd0, 2, 1).e, o);

    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       addr = $urandom;
        1:       addr = BASE + $urandom_range(0, 15) - 32'd8;
        2:       addr = LIMIT + $urandom_range(0, 15) - 32'd8;
        default: addr = $urandom_range(BASE, LIMIT);
      endcase
      sdata = $urandom;
      rdata = $urandom;
      ack   = $urandom_range(0, TO + 1);
      e = model(op, addr, sdata, rdata, ack);
      run_req(op, addr, sdata, rdata, ack, o);
      compare($sformatf("rand%0d_op%0d_a%h", i, op, addr), e, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
